// File: rtl/memoria_pkg.sv
// Shared definitions for the parametrised program/data memory: default widths,
// clear-sequencer state encoding and control-unit opcodes for image generation.
package memoria_pkg;

    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_ADDR_W = 10;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Opcodes shared with the control unit; only referenced when building INIT_FILE images.
    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_LOAD  = 6'h01;
    localparam logic [5:0] OP_STORE = 6'h02;
    localparam logic [5:0] OP_ADD   = 6'h03;
    localparam logic [5:0] OP_SUB   = 6'h04;
    localparam logic [5:0] OP_JUMP  = 6'h05;
    localparam logic [5:0] OP_BEQ   = 6'h06;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // Bits needed to index a DEPTH-word array (at least one).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Clear sequencer: sweeps zeros through every word of the array and flags busy
// for exactly DEPTH cycles per sweep.
module mem_clear_seq
    import memoria_pkg::*;
#(
    parameter int unsigned DEPTH          = 1024,
    parameter bit          CLEAR_ON_RESET = 1'b0,
    localparam int unsigned IW            = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    output logic          busy,
    output logic          clr_we,
    output logic [IW-1:0] clr_addr
);

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // clear is deliberately not looked at here so a sweep never restarts.
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == ST_CLEAR);
    // No array write on a reset edge, so an aborted sweep leaves the current word intact.
    assign clr_we   = busy && !reset;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/memoria_param.sv
// Parametrised RAM: one byte-enabled write port, two registered read ports with
// write-first forwarding, address range checking and a hardware clear sweep.
module memoria_param
    import memoria_pkg::*;
#(
    parameter int unsigned DATA_W         = MEM_DATA_W,
    parameter int unsigned ADDR_W         = MEM_ADDR_W,
    parameter int unsigned DEPTH          = 1024,
    parameter string       INIT_FILE      = "",
    parameter bit          CLEAR_ON_RESET = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd0_en,
    input  logic [ADDR_W-1:0]   rd0_addr,
    output logic [DATA_W-1:0]   rd0_data,
    output logic                rd0_valid,
    input  logic                rd1_en,
    input  logic [ADDR_W-1:0]   rd1_addr,
    output logic [DATA_W-1:0]   rd1_data,
    output logic                rd1_valid,
    input  logic                clear,
    output logic                busy,
    output logic                addr_err
);

    localparam int unsigned     NB      = DATA_W / 8;
    localparam int unsigned     IW      = idx_width(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] ram [DEPTH];

    logic          clr_we;
    logic [IW-1:0] clr_addr;

    logic              wr_ok, rd0_ok, rd1_ok, wr_fire;
    logic [IW-1:0]     wr_idx, rd0_idx, rd1_idx;
    logic [DATA_W-1:0] rd0_word, rd1_word;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_word,
                                                input logic [DATA_W-1:0] new_word,
                                                input logic [NB-1:0]     be);
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    mem_clear_seq #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_ok   = in_range(wr_addr);
    assign rd0_ok  = in_range(rd0_addr);
    assign rd1_ok  = in_range(rd1_addr);
    assign wr_idx  = wr_addr[IW-1:0];
    assign rd0_idx = rd0_addr[IW-1:0];
    assign rd1_idx = rd1_addr[IW-1:0];
    assign wr_fire = wr_en && wr_ok && !busy && !reset;

    // Write-first: a read colliding with this cycle's write sees the merged word.
    always_comb begin
        rd0_word = ram[rd0_idx];
        rd1_word = ram[rd1_idx];
        if (wr_fire && (rd0_addr == wr_addr)) begin
            rd0_word = merge(ram[rd0_idx], wr_data, wr_be);
        end
        if (wr_fire && (rd1_addr == wr_addr)) begin
            rd1_word = merge(ram[rd1_idx], wr_data, wr_be);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            ram[clr_addr] <= '0;
        end else if (wr_fire) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    ram[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd0_data  <= '0;
            rd1_data  <= '0;
            rd0_valid <= 1'b0;
            rd1_valid <= 1'b0;
            addr_err  <= 1'b0;
        end else if (busy) begin
            rd0_valid <= 1'b0;
            rd1_valid <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            rd0_valid <= rd0_en;
            rd1_valid <= rd1_en;
            if (rd0_en) begin
                rd0_data <= rd0_ok ? rd0_word : '0;
            end
            if (rd1_en) begin
                rd1_data <= rd1_ok ? rd1_word : '0;
            end
            addr_err <= (wr_en && !wr_ok) || (rd0_en && !rd0_ok) || (rd1_en && !rd1_ok);
        end
    end

endmodule
